// File: rtl/skolem_check_pkg.sv
// Shared types and the bvsle(bvmul(x, s), t) predicate for the Skolem certifier.
//   state_e  : certifier FSM states
//   W_DEF    : default operand width
//   W_MAX    : widest operand width the predicate helper supports
//   mul_sle  : (x*s mod 2^w) <=s t, evaluated at width w
package skolem_check_pkg;

   localparam int unsigned W_DEF = 4;
   localparam int unsigned W_MAX = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      RESP   = 2'd2
   } state_e;

   // Operands arrive zero-extended to W_MAX bits. Shifting both sides left so that
   // bit w-1 lands on the W_MAX sign bit turns a w-bit signed compare into a
   // W_MAX-bit signed compare, and it also drops the product bits above w.
   function automatic logic mul_sle(input logic [W_MAX-1:0] x,
                                    input logic [W_MAX-1:0] s,
                                    input logic [W_MAX-1:0] t,
                                    input int unsigned      w);
      logic [W_MAX-1:0] prod;
      logic [W_MAX-1:0] prod_al;
      logic [W_MAX-1:0] t_al;
      int unsigned      sh;
      sh      = W_MAX - w;
      prod    = x * s;
      prod_al = prod << sh;
      t_al    = t << sh;
      return $signed(prod_al) <= $signed(t_al);
   endfunction

endpackage

// File: rtl/skolem_check_bvsle_bvmul_eval.sv
// Combinational evaluator for one candidate of bvsle(bvmul(x, s), t).
//   x, s, t : W-bit operands (t is two's complement)
//   sle_c   : 1 when the low W bits of x*s are <= t as signed values
module bvsle_bvmul_eval
   import skolem_check_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] s,
   input  logic [W-1:0] t,
   output logic         sle_c
);

   assign sle_c = mul_sle(W_MAX'(x), W_MAX'(s), W_MAX'(t), W);

endmodule

// File: rtl/skolem_check_bvsle_bvmul.sv
// Sequential certifier for a Skolem witness of bvsle(bvmul(x, s), t).
// Accepts (s, t, x) on a valid/ready handshake, checks the candidate x, then
// sweeps all 2^W values of x to count witnesses and find the smallest one.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake; in_s, in_t, in_x operands
//   out_valid/out_ready : result handshake
//   out_x_ok            : candidate satisfies the formula
//   out_exists          : some x satisfies the formula
//   out_pass            : out_x_ok | ~out_exists
//   out_count           : number of satisfying x (0..2^W)
//   out_first           : smallest satisfying x, 0 if none
module skolem_check_bvsle_bvmul
   import skolem_check_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_s,
   input  logic [W-1:0] in_t,
   input  logic [W-1:0] in_x,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_x_ok,
   output logic         out_exists,
   output logic         out_pass,
   output logic [W:0]   out_count,
   output logic [W-1:0] out_first
);

   localparam int unsigned CW       = W + 1;
   localparam logic [W-1:0] CNT_LAST = '1;

   state_e          state_q, state_d;
   logic [W-1:0]    s_q, s_d;
   logic [W-1:0]    t_q, t_d;
   logic [W-1:0]    x_q, x_d;
   logic [W-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]   count_q, count_d;
   logic [W-1:0]    first_q, first_d;
   logic            exists_q, exists_d;
   logic            x_ok_q, x_ok_d;
   logic            pass_q, pass_d;
   logic            ready_q, ready_d;
   logic            valid_q, valid_d;
   logic            x_sle_c;
   logic            cand_sle_c;

   // Candidate check runs on the operand mux output so x_ok is captured on the accept edge.
   bvsle_bvmul_eval #(.W(W)) u_eval_x (
      .x     (x_d),
      .s     (s_d),
      .t     (t_d),
      .sle_c (x_sle_c)
   );

   // Sweep evaluator on the current counter value.
   bvsle_bvmul_eval #(.W(W)) u_eval_sweep (
      .x     (cnt_q),
      .s     (s_q),
      .t     (t_q),
      .sle_c (cand_sle_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, datapath next values and registered output flags.
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      t_d      = t_q;
      x_d      = x_q;
      cnt_d    = cnt_q;
      count_d  = count_q;
      first_d  = first_q;
      exists_d = exists_q;
      x_ok_d   = x_ok_q;
      pass_d   = pass_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               s_d      = in_s;
               t_d      = in_t;
               x_d      = in_x;
               x_ok_d   = x_sle_c;
               cnt_d    = '0;
               count_d  = '0;
               first_d  = '0;
               exists_d = 1'b0;
               pass_d   = 1'b0;
               state_d  = SEARCH;
            end
         end
         SEARCH: begin
            if (cand_sle_c) begin
               count_d = count_q + CW'(1);
               if (!exists_q) begin
                  first_d  = cnt_q;
                  exists_d = 1'b1;
               end
            end
            pass_d = x_ok_q | ~exists_d;
            cnt_d  = cnt_q + W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
      valid_d = (state_d == RESP);
   end

   // Operand latches, sweep counter, accumulators and handshake flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q      <= '0;
         t_q      <= '0;
         x_q      <= '0;
         cnt_q    <= '0;
         count_q  <= '0;
         first_q  <= '0;
         exists_q <= 1'b0;
         x_ok_q   <= 1'b0;
         pass_q   <= 1'b0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         s_q      <= s_d;
         t_q      <= t_d;
         x_q      <= x_d;
         cnt_q    <= cnt_d;
         count_q  <= count_d;
         first_q  <= first_d;
         exists_q <= exists_d;
         x_ok_q   <= x_ok_d;
         pass_q   <= pass_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
      end
   end

   assign in_ready   = ready_q;
   assign out_valid  = valid_q;
   assign out_x_ok   = x_ok_q;
   assign out_exists = exists_q;
   assign out_pass   = pass_q;
   assign out_count  = count_q;
   assign out_first  = first_q;

endmodule

// File: tb/tb_skolem_check_bvsle_bvmul.sv
// Self-checking bench for skolem_check_bvsle_bvmul: transaction-level model plus
// directed literal cases, backpressure, ignored requests, reset mid-sweep and random traffic.
module tb_skolem_check_bvsle_bvmul;

   localparam int unsigned W = 4;
   localparam int N = 16;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_s;
   logic [W-1:0] in_t;
   logic [W-1:0] in_x;
   logic         out_valid;
   logic         out_ready;
   logic         out_x_ok;
   logic         out_exists;
   logic         out_pass;
   logic [W:0]   out_count;
   logic [W-1:0] out_first;

   skolem_check_bvsle_bvmul #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_s       (in_s),
      .in_t       (in_t),
      .in_x       (in_x),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_x_ok   (out_x_ok),
      .out_exists (out_exists),
      .out_pass   (out_pass),
      .out_count  (out_count),
      .out_first  (out_first)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int x_ok;
      int exists;
      int pass;
      int count;
      int first;
   } res_t;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic over the whole x range.
   function automatic int sval(input int v);
      return (v >= N / 2) ? v - N : v;
   endfunction

   function automatic int pred(input int x, input int s, input int t);
      return (sval((x * s) % N) <= sval(t)) ? 1 : 0;
   endfunction

   function automatic res_t model(input int s, input int t, input int x);
      res_t r;
      r.x_ok  = pred(x, s, t);
      r.count = 0;
      r.first = 0;
      for (int c = N - 1; c >= 0; c--) begin
         if (pred(c, s, t) != 0) begin
            r.count++;
            r.first = c;
         end
      end
      r.exists = (r.count > 0) ? 1 : 0;
      r.pass   = (r.x_ok != 0 || r.exists == 0) ? 1 : 0;
      return r;
   endfunction

   // Compare process: tracks the transaction phase and checks outputs every cycle.
   int   phase    = 0;
   int   left     = 0;
   int   cyc      = 0;
   int   last_acc = 0;
   int   n_acc    = 0;
   res_t mexp;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_in_ready", int'(in_ready), 1);
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_count", int'(out_count), 0);
         chk("rst_exists", int'(out_exists), 0);
         chk("rst_x_ok", int'(out_x_ok), 0);
         chk("rst_pass", int'(out_pass), 0);
         chk("rst_first", int'(out_first), 0);
         phase = 0;
         n_acc = 0;
      end else begin
         chk("in_ready", int'(in_ready), (phase == 0) ? 1 : 0);
         chk("out_valid", int'(out_valid), (phase == 2) ? 1 : 0);
         if (phase == 2) begin
            chk("x_ok", int'(out_x_ok), mexp.x_ok);
            chk("exists", int'(out_exists), mexp.exists);
            chk("pass", int'(out_pass), mexp.pass);
            chk("count", int'(out_count), mexp.count);
            chk("first", int'(out_first), mexp.first);
         end
         case (phase)
            0: if (in_valid) begin
               mexp = model(int'(in_s), int'(in_t), int'(in_x));
               phase = 1;
               left  = N;
               if (n_acc > 0) chk("accept_spacing_ok", (cyc - last_acc >= N + 2) ? 1 : 0, 1);
               last_acc = cyc;
               n_acc++;
            end
            1: begin
               left--;
               if (left == 0) phase = 2;
            end
            default: if (out_ready) phase = 0;
         endcase
      end
   end

   // Driver: one request, optional ignored in_valid pulses during the sweep, result with backpressure.
   task automatic txn(input int s, input int t, input int x, input int hold, input int spam,
                      output res_t got, output int lat);
      bit  ok;
      time t_acc;
      got = '{0, 0, 0, 0, 0};
      lat = -1;
      in_s = W'(s);
      in_t = W'(t);
      in_x = W'(x);
      in_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chk("accept_timeout", 0, 1);
         @(posedge clk);
         #1 in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      t_acc = $time;
      #1 in_valid = 1'b0;
      for (int i = 0; i < spam; i++) begin
         in_valid = 1'b1;
         in_s = W'($urandom_range(0, N - 1));
         in_t = W'($urandom_range(0, N - 1));
         in_x = W'($urandom_range(0, N - 1));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         chk("result_timeout", 0, 1);
         @(posedge clk);
         #1;
         return;
      end
      lat = int'(($time - t_acc) / 10);
      got.x_ok   = int'(out_x_ok);
      got.exists = int'(out_exists);
      got.pass   = int'(out_pass);
      got.count  = int'(out_count);
      got.first  = int'(out_first);
      repeat (hold + 1) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   res_t r;
   res_t m;
   int   lat;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_s      = '0;
      in_t      = '0;
      in_x      = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Pin the model against hand-computed values.
      m = model(2, 0, 1);
      chk("model_s2_count", m.count, 10);
      chk("model_s2_pass", m.pass, 0);
      m = model(1, 8, 8);
      chk("model_s1_first", m.first, 8);

      txn(0, 0, 5, 0, 0, r, lat);
      chk("a_latency", lat, 16);
      chk("a_x_ok", r.x_ok, 1);
      chk("a_exists", r.exists, 1);
      chk("a_count", r.count, 16);
      chk("a_first", r.first, 0);
      chk("a_pass", r.pass, 1);

      txn(1, 8, 8, 0, 0, r, lat);
      chk("b_x_ok", r.x_ok, 1);
      chk("b_count", r.count, 1);
      chk("b_first", r.first, 8);
      chk("b_pass", r.pass, 1);

      txn(1, 8, 0, 0, 0, r, lat);
      chk("c_x_ok", r.x_ok, 0);
      chk("c_exists", r.exists, 1);
      chk("c_pass", r.pass, 0);

      txn(0, 15, 3, 0, 0, r, lat);
      chk("d_x_ok", r.x_ok, 0);
      chk("d_exists", r.exists, 0);
      chk("d_count", r.count, 0);
      chk("d_first", r.first, 0);
      chk("d_pass", r.pass, 1);

      // Backpressure in RESP and in_valid pulses during SEARCH.
      txn(2, 0, 1, 5, 6, r, lat);
      chk("e_latency", lat, 16);
      chk("e_x_ok", r.x_ok, 0);
      chk("e_count", r.count, 10);
      chk("e_first", r.first, 0);
      chk("e_pass", r.pass, 0);

      // Reset partway through a sweep.
      in_s = 4'd0;
      in_t = 4'd0;
      in_x = 4'd5;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_in_ready", int'(in_ready), 1);
      chk("mid_rst_count", int'(out_count), 0);
      chk("mid_rst_x_ok", int'(out_x_ok), 0);
      chk("mid_rst_exists", int'(out_exists), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      txn(2, 0, 1, 0, 0, r, lat);
      chk("f_latency", lat, 16);
      chk("f_x_ok", r.x_ok, 0);
      chk("f_count", r.count, 10);
      chk("f_first", r.first, 0);
      chk("f_pass", r.pass, 0);

      // Random traffic, checked by the compare process against the model.
      for (int k = 0; k < 25; k++) begin
         int rs, rt, rx;
         rs = int'($urandom_range(0, N - 1));
         rt = int'($urandom_range(0, N - 1));
         rx = int'($urandom_range(0, N - 1));
         txn(rs, rt, rx, int'($urandom_range(0, 3)), int'($urandom_range(0, 8)), r, lat);
         m = model(rs, rt, rx);
         chk("rnd_latency", lat, 16);
         chk("rnd_count", r.count, m.count);
         chk("rnd_pass", r.pass, m.pass);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
